// File: rtl/ram_cfg_pkg.sv
// Shared configuration for the partitioned one-hot register-file RAM:
// init patterns, init FSM state encoding and the partition row helper.
package ram_cfg_pkg;

  localparam int RAM_RESET_ZERO = 0;
  localparam int RAM_RESET_SEQ  = 1;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } init_state_t;

  function automatic int rows_f(input int depth, input int numParts);
    return depth / numParts;
  endfunction

endpackage

// File: rtl/ram_init_sweeper.sv
// Init sweep controller: walks one local row per cycle through the swept
// partitions, queues late ungates and produces the per-partition ready flags.
//
//   state | meaning
//   INIT  | sweeping row cnt of every partition in the sweep mask
//   READY | no sweep in progress; an ungate starts a new sweep
module ram_init_sweeper
  import ram_cfg_pkg::*;
#(
  parameter int NUM_PARTS = 4,
  parameter int ROWS      = 16,
  parameter int CW        = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PARTS-1:0] partGated_i,
  output logic [CW-1:0]        cnt_o,
  output logic [NUM_PARTS-1:0] initWrEn_o,
  output logic [NUM_PARTS-1:0] partReady_o
);

  localparam logic [0:0]    S_INIT   = INIT;
  localparam logic [0:0]    S_READY  = READY;
  localparam logic [CW-1:0] LAST_ROW = CW'(ROWS - 1);

  logic [0:0]           state, stateNext;
  logic [CW-1:0]        cnt, cntNext;
  logic [NUM_PARTS-1:0] sweepMask, sweepNext, pendMask, pendNext;
  logic [NUM_PARTS-1:0] gatedQ, ungate, sweepLive, pendLive, partReadyNext;

  // A partition gated now drops out of any sweep immediately.
  assign ungate    = gatedQ & ~partGated_i;
  assign sweepLive = sweepMask & ~partGated_i;
  assign pendLive  = pendMask & ~partGated_i;

  assign cnt_o      = cnt;
  assign initWrEn_o = (state == S_INIT) ? sweepLive : '0;

  always_comb begin
    stateNext     = state;
    cntNext       = cnt;
    sweepNext     = sweepLive;
    pendNext      = pendLive;
    partReadyNext = partReady_o & ~partGated_i;
    case (state)
      S_INIT: begin
        if (cnt == LAST_ROW) begin
          cntNext       = '0;
          partReadyNext = partReadyNext | sweepLive;
          pendNext      = '0;
          if ((pendLive | ungate) != '0) begin
            sweepNext = pendLive | ungate;
          end else begin
            stateNext = S_READY;
            sweepNext = '0;
          end
        end else begin
          cntNext  = cnt + CW'(1);
          pendNext = pendLive | ungate;
        end
      end
      default: begin
        if (ungate != '0) begin
          stateNext = S_INIT;
          sweepNext = ungate;
          cntNext   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_INIT;
      cnt         <= '0;
      sweepMask   <= ~partGated_i;
      pendMask    <= '0;
      gatedQ      <= partGated_i;
      partReady_o <= '0;
    end else begin
      state       <= stateNext;
      cnt         <= cntNext;
      sweepMask   <= sweepNext;
      pendMask    <= pendNext;
      gatedQ      <= partGated_i;
      partReady_o <= partReadyNext;
    end
  end

endmodule

// File: rtl/ram_partitioned_onehot.sv
// Multi-port register-file RAM with one-hot addresses and gateable partitions.
// Define RAM_WR_BYPASS_EN to forward same-cycle accepted write data to reads.
module ram_partitioned_onehot
  import ram_cfg_pkg::*;
#(
  parameter int DEPTH        = 64,
  parameter int WIDTH        = 32,
  parameter int NUM_WR_PORTS = 4,
  parameter int NUM_RD_PORTS = 8,
  parameter int NUM_PARTS    = 4,
  parameter int RESET_VAL    = RAM_RESET_ZERO,
  parameter int SEQ_START    = 0
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_PARTS-1:0]                  partGated_i,
  input  logic [NUM_RD_PORTS-1:0][DEPTH-1:0]    addr_i,
  output logic [NUM_RD_PORTS-1:0][WIDTH-1:0]    data_o,
  input  logic [NUM_WR_PORTS-1:0][DEPTH-1:0]    addrWr_i,
  input  logic [NUM_WR_PORTS-1:0][WIDTH-1:0]    dataWr_i,
  input  logic [NUM_WR_PORTS-1:0]               wrEn_i,
  output logic [NUM_PARTS-1:0]                  partReady_o,
  output logic                                  ramReady_o
);

  localparam int ROWS = rows_f(DEPTH, NUM_PARTS);
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [WIDTH-1:0]                 mem [DEPTH];
  logic [CW-1:0]                    cnt;
  logic [NUM_PARTS-1:0]             initWrEn;
  logic [DEPTH-1:0]                 rowReady, rowGated;
  logic [NUM_WR_PORTS-1:0][AW-1:0]  wrRow;
  logic [NUM_WR_PORTS-1:0]          wrAccept;
  logic [NUM_RD_PORTS-1:0][AW-1:0]  rdRow;

  // Multi-hot selects the highest set row; all-zero selects row 0.
  function automatic logic [AW-1:0] highIdx(input logic [DEPTH-1:0] oh);
    logic [AW-1:0] idx;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (oh[i]) idx = AW'(i);
    end
    return idx;
  endfunction

  function automatic logic [WIDTH-1:0] initVal(input logic [AW-1:0] row);
    if (RESET_VAL == RAM_RESET_SEQ) return WIDTH'(SEQ_START) + WIDTH'(row);
    else return '0;
  endfunction

  ram_init_sweeper #(
    .NUM_PARTS (NUM_PARTS),
    .ROWS      (ROWS),
    .CW        (CW)
  ) uSweeper (
    .clk         (clk),
    .reset       (reset),
    .partGated_i (partGated_i),
    .cnt_o       (cnt),
    .initWrEn_o  (initWrEn),
    .partReady_o (partReady_o)
  );

  for (genvar g = 0; g < DEPTH; g++) begin : gRow
    assign rowReady[g] = partReady_o[g / ROWS];
    assign rowGated[g] = partGated_i[g / ROWS];
  end

  always_comb begin
    for (int w = 0; w < NUM_WR_PORTS; w++) begin
      wrRow[w]    = highIdx(addrWr_i[w]);
      wrAccept[w] = wrEn_i[w] & ~reset & rowReady[wrRow[w]] & ~rowGated[wrRow[w]];
    end
    for (int r = 0; r < NUM_RD_PORTS; r++) begin
      rdRow[r] = highIdx(addr_i[r]);
    end
  end

  // Sweep writes and user writes never target the same partition, and
  // ascending port order lets the highest port win a shared row.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int p = 0; p < NUM_PARTS; p++) begin
        if (initWrEn[p]) mem[AW'(p * ROWS) + AW'(cnt)] <= initVal(AW'(p * ROWS) + AW'(cnt));
      end
      for (int w = 0; w < NUM_WR_PORTS; w++) begin
        if (wrAccept[w]) mem[wrRow[w]] <= dataWr_i[w];
      end
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_RD_PORTS; r++) begin
      data_o[r] = rowReady[rdRow[r]] ? mem[rdRow[r]] : '0;
`ifdef RAM_WR_BYPASS_EN
      for (int w = 0; w < NUM_WR_PORTS; w++) begin
        if (wrAccept[w] && (wrRow[w] == rdRow[r])) data_o[r] = dataWr_i[w];
      end
`else
`endif
    end
  end

  assign ramReady_o = ~reset & (&(partGated_i | partReady_o));

endmodule
